csm_rf_arbiter: RTL and testbench
=================================

Name: csm_rf_arbiter

Overview:
- Arbitrates ownership of the shared csm register file (2^ADD_WIDTH x DATA_WIDTH) between process A and process B.
- A process requests ownership, performs any number of reads/writes while granted, then releases.
- Fair round-robin on contention; all register-file port signals are registered.
- Sits between the two process interfaces and the register-file storage inside csm.

Parameters:
DATA_WIDTH, 32, register data width
ADD_WIDTH, 5, register address width
MAX_HOLD, 64, max cycles one owner may hold the grant (used only with the optional feature); legal range 2..65535

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
a_req  input  1  A requests ownership (level)
a_rel  input  1  A releases ownership (honoured only while a_gnt=1)
a_acc  input  1  A access valid
a_we  input  1  1=write, 0=read
a_addr  input  ADD_WIDTH  A access address
a_wdata  input  DATA_WIDTH  A write data
b_req, b_rel, b_acc, b_we, b_addr, b_wdata  input  as for A  process B equivalents
a_gnt  output  1  A owns register file
b_gnt  output  1  B owns register file
a_rdata  output  DATA_WIDTH  read data to A
a_rvalid  output  1  a_rdata valid, 1-cycle pulse
b_rdata  output  DATA_WIDTH  read data to B
b_rvalid  output  1  b_rdata valid, 1-cycle pulse
a_timeout  output  1  A forcibly revoked, 1-cycle pulse
b_timeout  output  1  B forcibly revoked, 1-cycle pulse
rf_we  output  1  register-file write enable
rf_re  output  1  register-file read strobe
rf_addr  output  ADD_WIDTH  register-file address
rf_wdata  output  DATA_WIDTH  register-file write data
rf_rdata  input  DATA_WIDTH  combinational read data for rf_addr

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values:
  - state IDLE, rr pointer = A;
  - a_gnt, b_gnt, rf_we, rf_re, a_rvalid, b_rvalid, a_timeout, b_timeout = 0;
  - rf_addr, rf_wdata, a_rdata, b_rdata = 0.
  - Reset mid-operation drops in-flight reads immediately; no rvalid is issued for them.
- States: IDLE, GRANT_A, GRANT_B, REVOKE.
- Arbitration, evaluated in IDLE and in REVOKE:
  - Only one req high: that process is granted.
  - Both req high: the process indicated by rr is granted; rr then points to the other process.
  - No req: go to / stay in IDLE.
- Grant timing: gnt rises on the edge after req is sampled, i.e. 1-cycle latency from IDLE.
- GRANT_X:
  - x_gnt=1; the other gnt=0.
  - x_req is ignored while granted.
  - Accesses from the non-owner are ignored, including an acc asserted during REVOKE/IDLE.
- Access path, owner only:
  - x_acc sampled at edge N drives rf_addr/rf_wdata/rf_we (write) or rf_re (read) during cycle N+1.
  - Writes: rf_we is a 1-cycle pulse.
  - Reads: rf_rdata is captured at edge N+2 into x_rdata, with x_rvalid=1 for cycle N+2. Read latency is 2 cycles.
  - The rvalid destination uses an owner tag captured with the access, so it is unaffected by a later grant change.
  - Back-to-back accesses are allowed every cycle.
- Release:
  - x_rel with x_gnt=1 at edge N: state becomes REVOKE at N+1 and x_gnt falls at N+1.
  - An access in the same cycle as rel is still performed.
  - REVOKE lasts exactly 1 cycle and arbitrates, so a new grant appears at N+2. Minimum handoff gap is 1 cycle with no grant.
  - A releasing process that keeps req high is re-arbitrated normally. rr ensures the other process wins if it is also requesting.
- rel while not granted: ignored.
- Simultaneous rel and access: the access completes, then REVOKE.

Optional Feature:
Macro CSM_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter clears on grant entry and increments each GRANT_X cycle.
  - If the counter equals MAX_HOLD-1 and x_rel=0, the next state is REVOKE and x_timeout pulses for that REVOKE cycle.
  - An access in the final granted cycle is still performed.
  - A release in the final cycle takes priority: no timeout pulse.
- Not defined:
  - No counter is built; ownership is unbounded.
  - a_timeout and b_timeout are tied to 0.

Test Plan:
1. Reset, then a_req=1 only -> a_gnt=1 one cycle later; write addr 3 data 0xDEADBEEF, then read addr 3 -> a_rvalid pulses 2 cycles after the read acc with a_rdata=0xDEADBEEF.
2. a_req and b_req both rise in the same cycle from reset -> A granted (rr=A). A releases while both keep req high -> 1 idle cycle, then b_gnt=1. B releases -> a_gnt=1.
3. B issues acc write addr 7 data 0x55 while A owns -> no rf_we pulse; a later A read of addr 7 returns the prior value (0 after reset).
4. A issues a read on the same cycle as a_rel while B is waiting -> a_rvalid still delivered to A at N+2, coincident with b_gnt rising; b_rvalid stays 0.
5. With CSM_HOLD_TIMEOUT_EN, MAX_HOLD=4: A granted, never releases -> a_gnt drops after 4 granted cycles, a_timeout=1 for 1 cycle, and a waiting B is granted on the next edge. Without the macro -> a_gnt stays high indefinitely and a_timeout=0.
6. Assert reset during an in-flight read -> all outputs return to reset values asynchronously and no rvalid follows.

Source files
------------

// File: rtl/csm_rf_arbiter_if.sv
// Process A/B ownership + access signals and the register-file port of csm_rf_arbiter.
// slave is the arbiter's view; master is the surrounding csm logic (processes and storage).
interface csm_rf_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 5
);
  logic                  a_req, a_rel, a_acc, a_we;
  logic [ADD_WIDTH-1:0]  a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  b_req, b_rel, b_acc, b_we;
  logic [ADD_WIDTH-1:0]  b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;

  logic                  a_gnt, b_gnt;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  logic                  a_rvalid, b_rvalid;
  logic                  a_timeout, b_timeout;

  logic                  rf_we, rf_re;
  logic [ADD_WIDTH-1:0]  rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport slave (
    input  a_req, a_rel, a_acc, a_we, a_addr, a_wdata,
    input  b_req, b_rel, b_acc, b_we, b_addr, b_wdata,
    input  rf_rdata,
    output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    output a_timeout, b_timeout,
    output rf_we, rf_re, rf_addr, rf_wdata
  );

  modport master (
    output a_req, a_rel, a_acc, a_we, a_addr, a_wdata,
    output b_req, b_rel, b_acc, b_we, b_addr, b_wdata,
    output rf_rdata,
    input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    input  a_timeout, b_timeout,
    input  rf_we, rf_re, rf_addr, rf_wdata
  );
endinterface

// File: rtl/csm_rf_arbiter.sv
// Round-robin ownership arbiter for the shared csm register file, registered access path.
// Define CSM_HOLD_TIMEOUT_EN to force a revoke after MAX_HOLD granted cycles.
module csm_rf_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 5,
  parameter int MAX_HOLD   = 64
) (
  input logic             clk,
  input logic             reset,
  csm_rf_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, REVOKE} state_e;

  state_e                state_q;
  logic                  rr_q;
  logic                  a_gnt_q, b_gnt_q;
  logic                  rf_we_q, rf_re_q, rd_tag_q;
  logic [ADD_WIDTH-1:0]  rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  a_rvalid_q, b_rvalid_q;

  logic                  pick_a, pick_b, hold_expired;
  logic                  own_acc, own_we;
  logic [ADD_WIDTH-1:0]  own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;

  // An out-of-range MAX_HOLD leaves this marker block in the elaborated hierarchy.
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_max_hold_out_of_range
  end

  // rr_q=0 favours A on contention, rr_q=1 favours B.
  assign pick_a = bus.a_req && (!bus.b_req || !rr_q);
  assign pick_b = bus.b_req && (!bus.a_req ||  rr_q);

  always_comb begin
    own_acc   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    if (state_q == GRANT_A) begin
      own_acc   = bus.a_acc;
      own_we    = bus.a_we;
      own_addr  = bus.a_addr;
      own_wdata = bus.a_wdata;
    end else if (state_q == GRANT_B) begin
      own_acc   = bus.b_acc;
      own_we    = bus.b_we;
      own_addr  = bus.b_addr;
      own_wdata = bus.b_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
    end else begin
      case (state_q)
        GRANT_A: if (bus.a_rel || hold_expired) begin
          state_q <= REVOKE;
          a_gnt_q <= 1'b0;
        end
        GRANT_B: if (bus.b_rel || hold_expired) begin
          state_q <= REVOKE;
          b_gnt_q <= 1'b0;
        end
        // IDLE and REVOKE both arbitrate; each grant hands priority to the other side.
        default: begin
          if (pick_a) begin
            state_q <= GRANT_A;
            a_gnt_q <= 1'b1;
            rr_q    <= 1'b1;
          end else if (pick_b) begin
            state_q <= GRANT_B;
            b_gnt_q <= 1'b1;
            rr_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Read data returns to whoever issued the read, tracked by rd_tag_q (1 = B).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_re_q    <= 1'b0;
      rd_tag_q   <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      rf_we_q <= own_acc && own_we;
      rf_re_q <= own_acc && !own_we;
      if (own_acc) begin
        rf_addr_q  <= own_addr;
        rf_wdata_q <= own_wdata;
        rd_tag_q   <= (state_q == GRANT_B);
      end
      a_rvalid_q <= rf_re_q && !rd_tag_q;
      b_rvalid_q <= rf_re_q &&  rd_tag_q;
      if (rf_re_q && !rd_tag_q) a_rdata_q <= bus.rf_rdata;
      if (rf_re_q &&  rd_tag_q) b_rdata_q <= bus.rf_rdata;
    end
  end

`ifdef CSM_HOLD_TIMEOUT_EN
  logic [15:0] hold_q;
  logic        a_timeout_q, b_timeout_q;

  assign hold_expired = (hold_q == 16'(MAX_HOLD - 1));

  // Counter is zero outside a grant, so every new grant starts counting from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      a_timeout_q <= 1'b0;
      b_timeout_q <= 1'b0;
    end else begin
      hold_q      <= (state_q == GRANT_A || state_q == GRANT_B) ? hold_q + 16'd1 : '0;
      a_timeout_q <= (state_q == GRANT_A) && hold_expired && !bus.a_rel;
      b_timeout_q <= (state_q == GRANT_B) && hold_expired && !bus.b_rel;
    end
  end

  assign bus.a_timeout = a_timeout_q;
  assign bus.b_timeout = b_timeout_q;
`else
  assign hold_expired  = 1'b0;
  assign bus.a_timeout = 1'b0;
  assign bus.b_timeout = 1'b0;
`endif

  assign bus.a_gnt    = a_gnt_q;
  assign bus.b_gnt    = b_gnt_q;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_re    = rf_re_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
endmodule

// File: tb/tb_csm_rf_arbiter.sv
// Self-checking bench for csm_rf_arbiter: a directed vector table plus hand-written
// sequences for contention, release handoff, hold timeout and reset during a read.
module tb_csm_rf_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csm_rf_arbiter_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

  csm_rf_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MAX_HOLD(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register-file storage model: combinational read, write on the clock edge.
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  assign bus.rf_rdata = mem[bus.rf_addr];
  always @(posedge clk) if (bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;

`ifdef CSM_HOLD_TIMEOUT_EN
  csm_rf_arbiter_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) busT ();
  assign busT.rf_rdata = '0;

  csm_rf_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MAX_HOLD(4)) dutT (
    .clk   (clk),
    .reset (reset),
    .bus   (busT)
  );
`endif

  // Control nibbles are {req, rel, acc, we}; expCtl is {a_gnt, b_gnt, rf_we, rf_re};
  // expRv is {a_rvalid, b_rvalid} and expRdata belongs to whichever rvalid is set.
  typedef struct {
    string         name;
    logic [3:0]    aCtl;
    logic [AW-1:0] aAddr;
    logic [DW-1:0] aData;
    logic [3:0]    bCtl;
    logic [AW-1:0] bAddr;
    logic [DW-1:0] bData;
    logic [3:0]    expCtl;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [1:0]    expRv;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, DW'(actual), DW'(expected));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    {bus.a_req, bus.a_rel, bus.a_acc, bus.a_we} = '0;
    {bus.b_req, bus.b_rel, bus.b_acc, bus.b_we} = '0;
    bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_addr = '0; bus.b_wdata = '0;
`ifdef CSM_HOLD_TIMEOUT_EN
    {busT.a_req, busT.a_rel, busT.a_acc, busT.a_we} = '0;
    {busT.b_req, busT.b_rel, busT.b_acc, busT.b_we} = '0;
    busT.a_addr = '0; busT.a_wdata = '0;
    busT.b_addr = '0; busT.b_wdata = '0;
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    {bus.a_req, bus.a_rel, bus.a_acc, bus.a_we} = v.aCtl;
    {bus.b_req, bus.b_rel, bus.b_acc, bus.b_we} = v.bCtl;
    bus.a_addr = v.aAddr; bus.a_wdata = v.aData;
    bus.b_addr = v.bAddr; bus.b_wdata = v.bData;
  endtask

  task automatic checkRow(input vec_t v);
    checkBit({v.name, ".a_gnt"},    bus.a_gnt,    v.expCtl[3]);
    checkBit({v.name, ".b_gnt"},    bus.b_gnt,    v.expCtl[2]);
    checkBit({v.name, ".rf_we"},    bus.rf_we,    v.expCtl[1]);
    checkBit({v.name, ".rf_re"},    bus.rf_re,    v.expCtl[0]);
    checkBit({v.name, ".a_rvalid"}, bus.a_rvalid, v.expRv[1]);
    checkBit({v.name, ".b_rvalid"}, bus.b_rvalid, v.expRv[0]);
    if (v.expCtl[1] || v.expCtl[0])
      checkOutput({v.name, ".rf_addr"}, DW'(bus.rf_addr), DW'(v.expAddr));
    if (v.expCtl[1]) checkOutput({v.name, ".rf_wdata"}, bus.rf_wdata, v.expWdata);
    if (v.expRv[1])  checkOutput({v.name, ".a_rdata"}, bus.a_rdata, v.expRdata);
    if (v.expRv[0])  checkOutput({v.name, ".b_rdata"}, bus.b_rdata, v.expRdata);
  endtask

  task automatic checkResetValues(input string tag);
    checkBit({tag, ".a_gnt"},     bus.a_gnt,     1'b0);
    checkBit({tag, ".b_gnt"},     bus.b_gnt,     1'b0);
    checkBit({tag, ".rf_we"},     bus.rf_we,     1'b0);
    checkBit({tag, ".rf_re"},     bus.rf_re,     1'b0);
    checkBit({tag, ".a_rvalid"},  bus.a_rvalid,  1'b0);
    checkBit({tag, ".b_rvalid"},  bus.b_rvalid,  1'b0);
    checkBit({tag, ".a_timeout"}, bus.a_timeout, 1'b0);
    checkBit({tag, ".b_timeout"}, bus.b_timeout, 1'b0);
    checkOutput({tag, ".rf_addr"},  DW'(bus.rf_addr), '0);
    checkOutput({tag, ".rf_wdata"}, bus.rf_wdata, '0);
    checkOutput({tag, ".a_rdata"},  bus.a_rdata,  '0);
    checkOutput({tag, ".b_rdata"},  bus.b_rdata,  '0);
  endtask

  initial begin
    idleInputs();

    //          name               aCtl     aAddr aData         bCtl     bAddr bData  expCtl   expAddr expWdata      expRv  expRdata
    vecs.push_back('{"grant_a",     4'b1000, 5'd0, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b1000, 5'd0,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"write3",      4'b1011, 5'd3, 32'hDEADBEEF, 4'b0000, 5'd0, 32'h0,  4'b1010, 5'd3,   32'hDEADBEEF, 2'b00, 32'h0});
    vecs.push_back('{"read3",       4'b1010, 5'd3, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b1001, 5'd3,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"write9",      4'b1011, 5'd9, 32'h00001234, 4'b0000, 5'd0, 32'h0,  4'b1010, 5'd9,   32'h00001234, 2'b10, 32'hDEADBEEF});
    vecs.push_back('{"read9",       4'b1010, 5'd9, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b1001, 5'd9,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"b_wr_ignored",4'b1000, 5'd0, 32'h0,        4'b0011, 5'd7, 32'h55, 4'b1000, 5'd0,   32'h0,        2'b10, 32'h00001234});
    vecs.push_back('{"read7",       4'b1010, 5'd7, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b1001, 5'd7,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"read7_data",  4'b1000, 5'd0, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b1000, 5'd0,   32'h0,        2'b10, 32'h0});
    vecs.push_back('{"a_release",   4'b0100, 5'd0, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b0000, 5'd0,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"idle",        4'b0000, 5'd0, 32'h0,        4'b0000, 5'd0, 32'h0,  4'b0000, 5'd0,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"stray_rel",   4'b0100, 5'd0, 32'h0,        4'b1000, 5'd0, 32'h0,  4'b0100, 5'd0,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"b_read3",     4'b0000, 5'd0, 32'h0,        4'b1010, 5'd3, 32'h0,  4'b0101, 5'd3,   32'h0,        2'b00, 32'h0});
    vecs.push_back('{"b_rdata",     4'b0000, 5'd0, 32'h0,        4'b1000, 5'd0, 32'h0,  4'b0100, 5'd0,   32'h0,        2'b01, 32'hDEADBEEF});
    vecs.push_back('{"b_release",   4'b0000, 5'd0, 32'h0,        4'b0100, 5'd0, 32'h0,  4'b0000, 5'd0,   32'h0,        2'b00, 32'h0});

    #2;
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      tick();
      checkRow(vecs[i]);
    end

    // Contention from reset: A first, then B after a one-cycle gap, then back to A.
    doReset();
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    tick();
    checkBit("rr.a_first", bus.a_gnt, 1'b1);
    checkBit("rr.b_wait",  bus.b_gnt, 1'b0);
    @(negedge clk); bus.a_rel = 1'b1;
    tick();
    checkBit("rr.gap_a", bus.a_gnt, 1'b0);
    checkBit("rr.gap_b", bus.b_gnt, 1'b0);
    @(negedge clk); bus.a_rel = 1'b0;
    tick();
    checkBit("rr.b_second", bus.b_gnt, 1'b1);
    checkBit("rr.a_off",    bus.a_gnt, 1'b0);
    @(negedge clk); bus.b_rel = 1'b1;
    tick();
    checkBit("rr.gap2_b", bus.b_gnt, 1'b0);
    @(negedge clk); bus.b_rel = 1'b0;
    tick();
    checkBit("rr.a_third", bus.a_gnt, 1'b1);
    checkBit("rr.b_off",   bus.b_gnt, 1'b0);

    // Read issued together with release: data still reaches A as B takes over.
    doReset();
    bus.a_req = 1'b1;
    tick();
    checkBit("relrd.a_gnt", bus.a_gnt, 1'b1);
    @(negedge clk);
    bus.b_req = 1'b1; bus.a_req = 1'b0; bus.a_rel = 1'b1;
    bus.a_acc = 1'b1; bus.a_we = 1'b0;  bus.a_addr = 5'd3;
    tick();
    checkBit("relrd.gap_a", bus.a_gnt, 1'b0);
    checkBit("relrd.gap_b", bus.b_gnt, 1'b0);
    checkBit("relrd.rf_re", bus.rf_re, 1'b1);
    @(negedge clk); bus.a_rel = 1'b0; bus.a_acc = 1'b0;
    tick();
    checkBit("relrd.b_gnt",    bus.b_gnt,    1'b1);
    checkBit("relrd.a_rvalid", bus.a_rvalid, 1'b1);
    checkOutput("relrd.a_rdata", bus.a_rdata, 32'hDEADBEEF);
    checkBit("relrd.b_rvalid", bus.b_rvalid, 1'b0);
    tick();
    checkBit("relrd.a_rvalid_end", bus.a_rvalid, 1'b0);

    // Hold limit: forced revoke after MAX_HOLD cycles, or unbounded ownership.
    doReset();
`ifdef CSM_HOLD_TIMEOUT_EN
    busT.a_req = 1'b1;
    tick();
    checkBit("hold.a_gnt0", busT.a_gnt, 1'b1);
    @(negedge clk); busT.b_req = 1'b1;
    for (int c = 1; c < 4; c++) begin
      tick();
      checkBit($sformatf("hold.a_gnt%0d", c), busT.a_gnt, 1'b1);
      checkBit($sformatf("hold.a_to%0d", c),  busT.a_timeout, 1'b0);
    end
    tick();
    checkBit("hold.a_dropped", busT.a_gnt,     1'b0);
    checkBit("hold.a_timeout", busT.a_timeout, 1'b1);
    checkBit("hold.b_wait",    busT.b_gnt,     1'b0);
    tick();
    checkBit("hold.b_gnt",    busT.b_gnt,     1'b1);
    checkBit("hold.to_pulse", busT.a_timeout, 1'b0);
`else
    bus.a_req = 1'b1;
    tick();
    @(negedge clk); bus.b_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checkBit($sformatf("nohold.a_gnt%0d", c), bus.a_gnt,     1'b1);
      checkBit($sformatf("nohold.a_to%0d", c),  bus.a_timeout, 1'b0);
    end
`endif

    // Asynchronous reset while a read is in flight.
    doReset();
    bus.a_req = 1'b1;
    tick();
    @(negedge clk); bus.a_acc = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd9;
    tick();
    checkBit("rstrd.rf_re", bus.rf_re, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkResetValues("rstrd");
    @(negedge clk);
    idleInputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkBit($sformatf("rstrd.no_rvalid%0d", c), bus.a_rvalid, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
